// File: rtl/simon_6496_word_io.sv
// Word-serial front end for a SIMON 64/96 core: assembles key/block words,
// runs core load/done handshakes and streams the 2-word result back out.
// Ports: clk, R (async high reset); wr_* input word stream (valid/ready,
//   wr_sel 0=key 1=data); rd_* output word stream; newKey/newData/enc_dec/
//   readData/KEY/BLOCK to core; loadKey/loadData/doneKey/doneData/outData
//   from core.
// Optional: SIMON_IO_DBLBUF_EN adds a spare block buffer that collects the
//   next block while the current one is in flight.
module simon_6496_word_io #(
    parameter int N  = 32,
    parameter int M  = 3,
    parameter int Cb = 2
) (
    input  logic             clk,
    input  logic             R,
    input  logic             wr_valid,
    input  logic             wr_sel,
    input  logic             wr_encdec,
    input  logic [N-1:0]     wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [N-1:0]     rd_data,
    input  logic             rd_ready,
    output logic             newKey,
    output logic             newData,
    output logic             enc_dec,
    output logic             readData,
    output logic [M*N-1:0]   KEY,
    output logic [2*N-1:0]   BLOCK,
    input  logic             loadKey,
    input  logic             loadData,
    input  logic             doneKey,
    input  logic             doneData,
    input  logic [2*N-1:0]   outData
);

    typedef enum logic [1:0] {K_IDLE, K_COLL, K_ISSUE, K_WAIT} kst_t;
    typedef enum logic [2:0] {
        D_IDLE, D_COLL, D_ISSUE, D_BUSY, D_OUT0, D_OUT1
    } dst_t;

    kst_t           kst_q, kst_d;
    dst_t           dst_q, dst_d;
    logic [Cb-1:0]  kcnt_q, kcnt_d;
    logic [Cb-1:0]  dcnt_q, dcnt_d;
    logic [M*N-1:0] key_q, key_d;
    logic [2*N-1:0] blk_q, blk_d;
    logic [2*N-1:0] res_q, res_d;
    logic           enc_q, enc_d;
    logic           kval_q, kval_d;
    logic           rdyk_q, rdyk_d;
    logic           rdyd_q, rdyd_d;
    logic           key_acc, dat_acc;

`ifdef SIMON_IO_DBLBUF_EN
    logic [2*N-1:0] sp_q, sp_d;
    logic [Cb-1:0]  spn_q, spn_d;
    logic           spe_q, spe_d;
`endif

    // Ready is registered per word kind; wr_sel only picks which one shows.
    assign wr_ready = wr_sel ? rdyd_q : rdyk_q;
    assign key_acc  = wr_valid & ~wr_sel & rdyk_q;
    assign dat_acc  = wr_valid & wr_sel & rdyd_q;

    always_comb begin
        kst_d  = kst_q;
        kcnt_d = kcnt_q;
        key_d  = key_q;
        kval_d = kval_q;
        unique case (kst_q)
            K_IDLE, K_COLL: begin
                if (key_acc) begin
                    key_d[int'(kcnt_q)*N +: N] = wr_data;
                    if (kcnt_q == Cb'(M-1)) begin
                        kcnt_d = '0;
                        kst_d  = K_ISSUE;
                    end else begin
                        kcnt_d = kcnt_q + 1'b1;
                        kst_d  = K_COLL;
                    end
                end
            end
            K_ISSUE: if (loadKey) kst_d = K_WAIT;
            K_WAIT: begin
                if (doneKey) begin
                    kst_d  = K_IDLE;
                    kval_d = 1'b1;
                end
            end
            default: kst_d = K_IDLE;
        endcase
    end

    always_comb begin
        dst_d  = dst_q;
        dcnt_d = dcnt_q;
        blk_d  = blk_q;
        enc_d  = enc_q;
        res_d  = res_q;
`ifdef SIMON_IO_DBLBUF_EN
        sp_d   = sp_q;
        spn_d  = spn_q;
        spe_d  = spe_q;
        if (dat_acc && (dst_q == D_BUSY || dst_q == D_OUT0 ||
                        dst_q == D_OUT1)) begin
            sp_d[int'(spn_q[0])*N +: N] = wr_data;
            if (spn_q == '0) spe_d = wr_encdec;
            spn_d = spn_q + 1'b1;
        end
`endif
        unique case (dst_q)
            D_IDLE, D_COLL: begin
                if (dat_acc) begin
                    blk_d[int'(dcnt_q[0])*N +: N] = wr_data;
                    if (dcnt_q == '0) begin
                        enc_d  = wr_encdec;
                        dcnt_d = Cb'(1);
                        dst_d  = D_COLL;
                    end else begin
                        dcnt_d = '0;
                        dst_d  = D_ISSUE;
                    end
                end
            end
            D_ISSUE: if (loadData) dst_d = D_BUSY;
            D_BUSY: begin
                if (doneData) begin
                    res_d = outData;
                    dst_d = D_OUT0;
                end
            end
            D_OUT0: if (rd_ready) dst_d = D_OUT1;
            D_OUT1: begin
                if (rd_ready) begin
`ifdef SIMON_IO_DBLBUF_EN
                    // Spare (including a word taken this cycle) moves in.
                    if (spn_d == Cb'(2)) begin
                        blk_d = sp_d;
                        enc_d = spe_d;
                        spn_d = '0;
                        dst_d = D_ISSUE;
                    end else if (spn_d == Cb'(1)) begin
                        blk_d[N-1:0] = sp_d[N-1:0];
                        enc_d        = spe_d;
                        dcnt_d       = Cb'(1);
                        spn_d        = '0;
                        dst_d        = D_COLL;
                    end else begin
                        dst_d = D_IDLE;
                    end
`else
                    dst_d = D_IDLE;
`endif
                end
            end
            default: dst_d = D_IDLE;
        endcase
    end

    always_comb begin
        rdyk_d = (kst_d == K_IDLE || kst_d == K_COLL) && dst_d == D_IDLE;
        rdyd_d = kval_d && kst_d == K_IDLE &&
                 (dst_d == D_IDLE || dst_d == D_COLL);
`ifdef SIMON_IO_DBLBUF_EN
        if (kval_d && kst_d == K_IDLE && spn_d != Cb'(2) &&
            (dst_d == D_BUSY || dst_d == D_OUT0 || dst_d == D_OUT1))
            rdyd_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            kst_q  <= K_IDLE;
            dst_q  <= D_IDLE;
            kcnt_q <= '0;
            dcnt_q <= '0;
            key_q  <= '0;
            blk_q  <= '0;
            res_q  <= '0;
            enc_q  <= 1'b0;
            kval_q <= 1'b0;
            rdyk_q <= 1'b0;
            rdyd_q <= 1'b0;
`ifdef SIMON_IO_DBLBUF_EN
            sp_q   <= '0;
            spn_q  <= '0;
            spe_q  <= 1'b0;
`endif
        end else begin
            kst_q  <= kst_d;
            dst_q  <= dst_d;
            kcnt_q <= kcnt_d;
            dcnt_q <= dcnt_d;
            key_q  <= key_d;
            blk_q  <= blk_d;
            res_q  <= res_d;
            enc_q  <= enc_d;
            kval_q <= kval_d;
            rdyk_q <= rdyk_d;
            rdyd_q <= rdyd_d;
`ifdef SIMON_IO_DBLBUF_EN
            sp_q   <= sp_d;
            spn_q  <= spn_d;
            spe_q  <= spe_d;
`endif
        end
    end

    assign newKey   = (kst_q == K_ISSUE) & loadKey;
    assign newData  = (dst_q == D_ISSUE) & loadData;
    assign readData = (dst_q == D_BUSY) & doneData;
    assign rd_valid = (dst_q == D_OUT0) | (dst_q == D_OUT1);
    assign rd_data  = (dst_q == D_OUT0) ? res_q[N-1:0] :
                      (dst_q == D_OUT1) ? res_q[2*N-1:N] : '0;
    assign KEY      = key_q;
    assign BLOCK    = blk_q;
    assign enc_dec  = enc_q;

endmodule

// File: tb/tb_simon_6496_word_io.sv
// Bench for simon_6496_word_io with a behavioural SIMON 64/96 core model.
// Directed known-answer, ordering, backpressure and reset vectors.
module tb_simon_6496_word_io;

    logic        clk = 1'b0;
    logic        R;
    logic        wr_valid, wr_sel, wr_encdec, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        newKey, newData, enc_dec, readData;
    logic [95:0] KEY;
    logic [63:0] BLOCK;
    logic        loadKey, loadData, doneKey, doneData;
    logic [63:0] outData;

    int ntests = 0;
    int nfail  = 0;

    simon_6496_word_io dut (
        .clk(clk), .R(R),
        .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_encdec(wr_encdec),
        .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .newKey(newKey), .newData(newData), .enc_dec(enc_dec),
        .readData(readData), .KEY(KEY), .BLOCK(BLOCK),
        .loadKey(loadKey), .loadData(loadData), .doneKey(doneKey),
        .doneData(doneData), .outData(outData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] fr(input logic [31:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    function automatic logic [63:0] simon(input logic [95:0] key,
                                          input logic [63:0] blk,
                                          input logic enc);
        logic [61:0] z2;
        logic [31:0] k [0:41];
        logic [31:0] x, y, t;
        z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
        k[0] = key[31:0];
        k[1] = key[63:32];
        k[2] = key[95:64];
        for (int i = 3; i < 42; i++) begin
            t = rol(k[i-1], 29);
            t = t ^ rol(t, 31);
            k[i] = 32'hfffffffc ^ {31'b0, z2[61-(i-3)]} ^ k[i-3] ^ t;
        end
        x = blk[63:32];
        y = blk[31:0];
        if (enc) begin
            for (int i = 0; i < 42; i++) begin
                t = x;
                x = y ^ fr(x) ^ k[i];
                y = t;
            end
        end else begin
            for (int i = 41; i >= 0; i--) begin
                t = y;
                y = x ^ fr(y) ^ k[i];
                x = t;
            end
        end
        return {x, y};
    endfunction

    // Core model
    logic [95:0] m_key;
    logic [63:0] m_blk;
    logic        m_enc, m_busy, m_keydone;
    int          rd_pulses = 0;
    int          kdly, ddly;

    initial begin
        logic nk, nd, rdp;
        loadKey = 1'b0; loadData = 1'b0; doneKey = 1'b0; doneData = 1'b0;
        outData = '0; m_key = '0; m_blk = '0; m_enc = 1'b0;
        m_busy = 1'b0; m_keydone = 1'b0; kdly = 0; ddly = 0;
        forever begin
            @(negedge clk);
            nk = newKey; nd = newData; rdp = readData;
            @(posedge clk);
            #1;
            if (R) begin
                kdly = 0; ddly = 0; doneKey = 1'b0; doneData = 1'b0;
                loadKey = 1'b1; loadData = 1'b1;
                m_busy = 1'b0; m_keydone = 1'b0;
                continue;
            end
            if (doneKey) begin
                doneKey = 1'b0; loadKey = 1'b1; m_keydone = 1'b1;
            end
            if (nk) begin
                m_key = KEY; loadKey = 1'b0; kdly = 4;
            end else if (kdly > 0) begin
                kdly--;
                if (kdly == 0) doneKey = 1'b1;
            end
            if (nd) begin
                m_blk = BLOCK; m_enc = enc_dec; loadData = 1'b0;
                m_busy = 1'b1; ddly = 6;
            end else if (ddly > 0) begin
                ddly--;
                if (ddly == 0) begin
                    outData = simon(m_key, m_blk, m_enc);
                    doneData = 1'b1;
                end
            end
            if (rdp) begin
                doneData = 1'b0; m_busy = 1'b0; loadData = 1'b1;
                rd_pulses++;
            end
        end
    end

    task automatic send(input logic sel, input logic ed,
                        input logic [31:0] d);
        int n = 0;
        wr_sel = sel; wr_encdec = ed; wr_data = d; wr_valid = 1'b1;
        @(negedge clk);
        while (!wr_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("wr_accept", {95'b0, wr_ready}, 96'd1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [31:0] exp);
        int n = 0;
        rd_ready = 1'b1;
        @(negedge clk);
        while (!rd_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(tag, {64'b0, rd_data}, {64'b0, exp});
        @(posedge clk);
        #1 rd_ready = 1'b0;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!m_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("core_busy", {95'b0, m_busy}, 96'd1);
    endtask

    task automatic stall_chk(input string tag, input logic sel);
        logic seen = 1'b0;
        wr_sel = sel; wr_data = 32'hdeadbeef; wr_encdec = 1'b1;
        wr_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            seen |= wr_ready;
        end
        wr_valid = 1'b0;
        chk(tag, {95'b0, seen}, 96'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic load_key();
        send(1'b0, 1'b0, 32'h03020100);
        send(1'b0, 1'b0, 32'h0b0a0908);
        send(1'b0, 1'b0, 32'h13121110);
    endtask

    initial begin
        int n, p0;
        logic stable;
        logic [31:0] d0;
        R = 1'b1; wr_valid = 1'b0; wr_sel = 1'b0; wr_encdec = 1'b0;
        wr_data = '0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {90'b0, wr_ready, rd_valid, newKey, newData,
                          readData, enc_dec}, 96'd0);
        chk("reset_key", KEY, 96'd0);
        chk("reset_blk", {32'b0, BLOCK}, 96'd0);
        #1 R = 1'b0;
        @(posedge clk);
        #1;

        stall_chk("data_before_key", 1'b1);
        load_key();

        // Data word pending from now; must stay stalled until doneKey.
        wr_sel = 1'b1; wr_encdec = 1'b1; wr_data = 32'h6e696c63;
        wr_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("data_after_donekey", {95'b0, m_keydone}, 96'd1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        chk("key_words", m_key, 96'h13121110_0b0a0908_03020100);
        send(1'b1, 1'b0, 32'h6f722067);
        wait_busy();
        chk("blk_words", {32'b0, m_blk}, {32'b0, 64'h6f722067_6e696c63});
        chk("enc_flag", {95'b0, m_enc}, 96'd1);
        stall_chk("key_during_busy", 1'b0);
        p0 = rd_pulses;
        recv("kat_enc_w0", 32'h111a8fc8);
        recv("kat_enc_w1", 32'h5ca2e27f);
        chk("enc_readdata", 96'(rd_pulses - p0), 96'd1);

        // Decrypt with output backpressure.
        p0 = rd_pulses;
        send(1'b1, 1'b0, 32'h111a8fc8);
        send(1'b1, 1'b1, 32'h5ca2e27f);
        n = 0;
        @(negedge clk);
        while (!rd_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        d0 = rd_data;
        chk("bp_first", {64'b0, d0}, {64'b0, 32'h6e696c63});
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!rd_valid || rd_data !== d0) stable = 1'b0;
        end
        chk("bp_hold", {95'b0, stable}, 96'd1);
        chk("bp_readdata", 96'(rd_pulses - p0), 96'd1);
        @(posedge clk);
        #1;
        recv("kat_dec_w0", 32'h6e696c63);
        recv("kat_dec_w1", 32'h6f722067);

`ifdef SIMON_IO_DBLBUF_EN
        send(1'b1, 1'b1, 32'h6e696c63);
        send(1'b1, 1'b0, 32'h6f722067);
        send(1'b1, 1'b0, 32'h111a8fc8);
        chk("dbl_busy_accept", {95'b0, m_busy}, 96'd1);
        send(1'b1, 1'b1, 32'h5ca2e27f);
        recv("dbl_a0", 32'h111a8fc8);
        recv("dbl_a1", 32'h5ca2e27f);
        recv("dbl_b0", 32'h6e696c63);
        recv("dbl_b1", 32'h6f722067);
`endif

        // Reset in the middle of a block.
        send(1'b1, 1'b1, 32'h6e696c63);
        send(1'b1, 1'b0, 32'h6f722067);
        wait_busy();
        @(negedge clk);
        #1 R = 1'b1;
        @(negedge clk);
        chk("midrst_ctl", {90'b0, wr_ready, rd_valid, newKey, newData,
                           readData, enc_dec}, 96'd0);
        chk("midrst_data", {wr_data & 32'h0, rd_data, BLOCK[63:32]},
            96'd0);
        chk("midrst_key", KEY, 96'd0);
        #1 R = 1'b0;
        @(posedge clk);
        #1;
        stall_chk("post_rst_data_stall", 1'b1);
        load_key();
        send(1'b1, 1'b1, 32'h6e696c63);
        send(1'b1, 1'b0, 32'h6f722067);
        recv("rst_kat_w0", 32'h111a8fc8);
        recv("rst_kat_w1", 32'h5ca2e27f);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
